// File: rtl/uart_pkg.sv
// Shared serial-link definitions: transmit FSM states and line levels.
// Used by uart_tx_block and the receive side of the link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_bits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/uart_tx_block_flex_counter.sv
// Flexible rollover counter used as the serial bit timer.
// Counts 1..i_rollover_val; o_rollover_flag is high while at the top value.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    i_clear,
  input  logic                    i_count_enable,
  input  logic [NUM_CNT_BITS-1:0] i_rollover_val,
  output logic                    o_rollover_flag
);

  logic [NUM_CNT_BITS-1:0] r_count;
  logic [NUM_CNT_BITS-1:0] w_count_nxt;
  logic                    r_flag;

  localparam logic [NUM_CNT_BITS-1:0] ONE =
    {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  always_comb begin
    w_count_nxt = r_count;
    if (i_clear) begin
      w_count_nxt = '0;
    end else if (i_count_enable) begin
      if (r_count == i_rollover_val) begin
        w_count_nxt = ONE;
      end else begin
        w_count_nxt = r_count + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_flag  <= (w_count_nxt == i_rollover_val);
    end
  end

  assign o_rollover_flag = r_flag;

endmodule

// File: rtl/uart_tx_block.sv
// Serial transmitter: start, DATA_BITS LSB-first, optional parity, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data.
import uart_pkg::*;

module uart_tx_block #(
  parameter int DATA_BITS  = 8,
  parameter int BIT_PERIOD = 10,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 serial_out
);

  localparam int TW = cnt_bits(BIT_PERIOD);
  localparam int BMAX =
    (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BW = cnt_bits(BMAX);

  localparam logic [TW-1:0] PERIOD    = TW'(BIT_PERIOD);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] BONE      = BW'(1);

  tx_state_t              r_state;
  tx_state_t              w_state_nxt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   w_shift_nxt;
  logic [BW-1:0]          r_bit_cnt;
  logic [BW-1:0]          w_bit_cnt_nxt;
  logic                   r_line;
  logic                   w_line_nxt;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_accept;
  logic                   w_tick;
  logic                   w_last;
  logic                   w_tmr_clear;
`ifdef UART_TX_PARITY_EN
  logic                   r_par;
  logic                   w_par_nxt;
`endif

  assign w_accept = tx_start && r_ready;

  // Timer parks at 0 in IDLE so an accept always starts it at 1.
  assign w_tmr_clear = ((r_state == IDLE) && !w_accept) || w_last;

  flex_counter #(
    .NUM_CNT_BITS(TW)
  ) u_bit_timer (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_clear        (w_tmr_clear),
    .i_count_enable (1'b1),
    .i_rollover_val (PERIOD),
    .o_rollover_flag(w_tick)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_last        = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt     = r_par;
`endif
    unique case (r_state)
      IDLE: begin
        w_bit_cnt_nxt = '0;
        if (w_accept) begin
          w_state_nxt = START;
          w_shift_nxt = tx_data;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = 1'b0;
`endif
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = r_par ^ r_shift[0];
`endif
          if (r_bit_cnt == LAST_DATA) begin
            w_bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt   = PARITY;
`else
            w_state_nxt   = STOP;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BONE;
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_bit_cnt == LAST_STOP) begin
            w_state_nxt   = IDLE;
            w_bit_cnt_nxt = '0;
            w_last        = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BONE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Line level is decoded from the next state so serial_out is a flop.
  always_comb begin
    w_line_nxt = LINE_IDLE;
    unique case (w_state_nxt)
      IDLE:    w_line_nxt = LINE_IDLE;
      START:   w_line_nxt = LINE_START;
      DATA:    w_line_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_line_nxt = w_par_nxt;
`else
      PARITY:  w_line_nxt = LINE_STOP;
`endif
      STOP:    w_line_nxt = LINE_STOP;
      default: w_line_nxt = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_line    <= LINE_IDLE;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_line    <= w_line_nxt;
      r_ready   <= (w_state_nxt == IDLE);
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= w_last;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_par <= 1'b0;
    end else begin
      r_par <= w_par_nxt;
    end
  end
`endif

  assign tx_ready   = r_ready;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;
  assign serial_out = r_line;

endmodule

// File: tb/tb_uart_tx_block.sv
// Bench for uart_tx_block: per-clock line model plus a mid-bit receiver.
// Honours UART_TX_PARITY_EN when computing the expected frame.
module tb_uart_tx_block;

  localparam int DB = 8;
  localparam int BP = 10;
  localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB  = 1 + DB + P + SB;
  localparam int LEN = NB * BP;

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic [DB-1:0] tx_data = '0;
  logic          tx_start = 1'b0;
  logic          tx_ready;
  logic          tx_busy;
  logic          tx_done;
  logic          serial_out;

  int total = 0;
  int bad   = 0;

  bit            rx_en = 1'b0;
  logic [DB-1:0] rxq[$];
  int            ferr = 0;

  uart_tx_block #(
    .DATA_BITS (DB),
    .BIT_PERIOD(BP),
    .STOP_BITS (SB)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .serial_out(serial_out)
  );

  always #5 clk = ~clk;

  // Frame bit b of payload d: start, data LSB first, parity, stops.
  function automatic logic exp_bit(input logic [DB-1:0] d,
                                   input int b);
    int ones;
    ones = 0;
    if (b == 0) return 1'b0;
    if (b <= DB) return d[b-1];
    if (P == 1 && b == DB + 1) begin
      for (int i = 0; i < DB; i++) ones += int'(d[i]);
      return (ones % 2) == 1;
    end
    return 1'b1;
  endfunction

  // Independent receiver sampling the middle of each bit.
  initial begin
    logic [DB-1:0] rd;
    forever begin
      @(negedge clk);
      if (rx_en && serial_out === 1'b0) begin
        repeat (BP / 2) @(negedge clk);
        if (serial_out !== 1'b0) ferr++;
        for (int i = 0; i < DB; i++) begin
          repeat (BP) @(negedge clk);
          rd[i] = serial_out;
        end
`ifdef UART_TX_PARITY_EN
        repeat (BP) @(negedge clk);
        if (serial_out !== ^rd) ferr++;
`endif
        for (int s = 0; s < SB; s++) begin
          repeat (BP) @(negedge clk);
          if (serial_out !== 1'b1) ferr++;
        end
        rxq.push_back(rd);
      end
    end
  end

  // Caller has raised tx_start with tx_data=d; accept is the next posedge.
  task automatic run_frame(input logic [DB-1:0] d, input bit keep,
                           input logic [DB-1:0] nd, input bit poke);
    @(posedge clk);
    #1;
    tx_data = nd;
    if (!keep) tx_start = 1'b0;
    for (int k = 0; k < LEN; k++) begin
      @(negedge clk);
      if (poke && k == LEN / 2) tx_start = 1'b1;
      if (poke && k == LEN / 2 + 1) tx_start = 1'b0;
      total++;
      if (serial_out !== exp_bit(d, k / BP)) begin
        bad++;
        $display("FAIL line d=%h cyc=%0d got=%b exp=%b",
                 d, k, serial_out, exp_bit(d, k / BP));
      end
      total++;
      if ({tx_ready, tx_busy, tx_done} !== 3'b010) begin
        bad++;
        $display("FAIL busy_flags d=%h cyc=%0d got=%b exp=010",
                 d, k, {tx_ready, tx_busy, tx_done});
      end
    end
    @(negedge clk);
    total++;
    if ({serial_out, tx_ready, tx_busy, tx_done} !== 4'b1101) begin
      bad++;
      $display("FAIL frame_end d=%h got=%b exp=1101", d,
               {serial_out, tx_ready, tx_busy, tx_done});
    end
  endtask

  task automatic test_reset();
    #7;
    n_rst = 1'b0;
    #1;
    total++;
    if ({serial_out, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_now got=%b exp=1100",
               {serial_out, tx_ready, tx_busy, tx_done});
    end
    repeat (2) @(negedge clk);
    total++;
    if ({serial_out, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_hold got=%b exp=1100",
               {serial_out, tx_ready, tx_busy, tx_done});
    end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({serial_out, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_idle got=%b exp=1100",
               {serial_out, tx_ready, tx_busy, tx_done});
    end
  endtask

  task automatic test_frame_a5();
    @(negedge clk);
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    run_frame(8'hA5, 1'b0, DB'($urandom), 1'b0);
    @(negedge clk);
    total++;
    if (tx_done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse got=%b exp=0", tx_done);
    end
  endtask

  task automatic test_parity_01();
    repeat (2) @(negedge clk);
    tx_data  = 8'h01;
    tx_start = 1'b1;
    run_frame(8'h01, 1'b0, 8'hFF, 1'b1);
  endtask

  task automatic test_back_to_back();
    repeat (3) @(negedge clk);
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    run_frame(8'h3C, 1'b1, 8'hC3, 1'b0);
    run_frame(8'hC3, 1'b0, DB'($urandom), 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [DB-1:0] d;
    @(negedge clk);
    tx_data  = 8'h00;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    repeat (4 * BP + 5) @(negedge clk);
    total++;
    if ({serial_out, tx_busy} !== 2'b01) begin
      bad++;
      $display("FAIL mid_bit3 got=%b exp=01", {serial_out, tx_busy});
    end
    #2;
    n_rst = 1'b0;
    #1;
    total++;
    if ({serial_out, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      bad++;
      $display("FAIL mid_abort got=%b exp=1100",
               {serial_out, tx_ready, tx_busy, tx_done});
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    d        = DB'($urandom);
    tx_data  = d;
    tx_start = 1'b1;
    run_frame(d, 1'b0, DB'($urandom), 1'b0);
  endtask

  task automatic test_loopback();
    logic [DB-1:0] sent[$];
    logic [DB-1:0] d;
    rx_en = 1'b1;
    for (int n = 0; n < 50; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d = DB'($urandom);
      sent.push_back(d);
      tx_data  = d;
      tx_start = 1'b1;
      run_frame(d, 1'b0, DB'($urandom), 1'b0);
    end
    repeat (BP) @(negedge clk);
    rx_en = 1'b0;
    for (int n = 0; n < 50; n++) begin
      total++;
      if (n >= rxq.size()) begin
        bad++;
        $display("FAIL loop_missing idx=%0d got=none exp=%h",
                 n, sent[n]);
      end else if (rxq[n] !== sent[n]) begin
        bad++;
        $display("FAIL loop_byte idx=%0d got=%h exp=%h",
                 n, rxq[n], sent[n]);
      end
    end
    total++;
    if (ferr != 0 || rxq.size() != 50) begin
      bad++;
      $display("FAIL loop_framing got=%0d/%0d exp=0/50",
               ferr, rxq.size());
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_parity_01();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
